// File: rtl/uni_shift_reg.sv
// Parametrised universal shift register: manual shift/rotate/load/clear modes
// plus a burst engine that performs LEN autonomous shifts with BUSY/DONE handshake.
module uni_shift_reg #(
    parameter int            N    = 8,
    parameter logic [N-1:0]  INIT = '0,
    parameter int            CW   = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    input  logic [2:0]    MODE,
    input  logic          SI,
    input  logic [N-1:0]  PI,
    input  logic          START,
    input  logic [CW-1:0] LEN,
    input  logic          DIR,
    output logic [N-1:0]  PO,
    output logic          SO_L,
    output logic          SO_R,
    output logic          BUSY,
    output logic          DONE
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (CE) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        // Accept edge only arms the engine; the first shift is on the next edge.
                        if (LEN != '0) begin
                            cnt_d   = LEN;
                            dir_d   = DIR;
                            state_d = SHIFT;
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        case (MODE)
                            3'd1:    q_d = {q_q[N-2:0], SI};
                            3'd2:    q_d = {SI, q_q[N-1:1]};
                            3'd3:    q_d = {q_q[N-2:0], q_q[N-1]};
                            3'd4:    q_d = {q_q[0], q_q[N-1:1]};
                            3'd5:    q_d = PI;
                            3'd6:    q_d = '0;
                            default: q_d = q_q;
                        endcase
                    end
                end
                SHIFT: begin
                    q_d   = dir_q ? {SI, q_q[N-1:1]} : {q_q[N-2:0], SI};
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            q_q     <= INIT;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign PO   = q_q;
    assign SO_L = q_q[N-1];
    assign SO_R = q_q[0];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_uni_shift_reg.sv
// Self-checking bench for uni_shift_reg (N=8, INIT=A5): directed scenarios plus
// randomized traffic, all compared against an integer-arithmetic reference model.
module tb_uni_shift_reg;

    localparam int N = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CE = 1'b1;
    logic [2:0]    MODE = 3'd0;
    logic          SI = 1'b0;
    logic [N-1:0]  PI = '0;
    logic          START = 1'b0;
    logic [CW-1:0] LEN = '0;
    logic          DIR = 1'b0;
    logic [N-1:0]  PO;
    logic          SO_L, SO_R, BUSY, DONE;

    uni_shift_reg #(.N(N), .INIT(8'hA5)) dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .MODE(MODE), .SI(SI), .PI(PI),
        .START(START), .LEN(LEN), .DIR(DIR), .PO(PO), .SO_L(SO_L), .SO_R(SO_R),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: register as an integer, burst as "shifts remaining".
    int mq, rem, mdir;
    bit mdone;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int shl(int v, int b); return ((v << 1) | b) & 255; endfunction
    function automatic int shr(int v, int b); return (v >> 1) | (b << 7); endfunction

    task automatic model_reset();
        mq = 'hA5; rem = 0; mdir = 0; mdone = 0;
    endtask

    task automatic model_edge();
        if (RESET) begin model_reset(); return; end
        if (!CE) return;
        mdone = 0;
        if (rem > 0) begin
            mq = mdir ? shr(mq, int'(SI)) : shl(mq, int'(SI));
            rem--;
            if (rem == 0) mdone = 1;
        end else if (START) begin
            if (LEN > 0) begin rem = int'(LEN); mdir = int'(DIR); end
            else mdone = 1;
        end else begin
            case (MODE)
                3'd1: mq = shl(mq, int'(SI));
                3'd2: mq = shr(mq, int'(SI));
                3'd3: mq = shl(mq, mq >> 7);
                3'd4: mq = shr(mq, mq & 1);
                3'd5: mq = int'(PI);
                3'd6: mq = 0;
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".po"},   32'(PO),   32'(mq));
        check_eq({tag, ".sol"},  32'(SO_L), 32'((mq >> 7) & 1));
        check_eq({tag, ".sor"},  32'(SO_R), 32'(mq & 1));
        check_eq({tag, ".busy"}, 32'(BUSY), 32'(rem > 0));
        check_eq({tag, ".done"}, 32'(DONE), 32'(mdone));
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [7:0] stream;
    int busy_cycles;

    initial begin
        model_reset();
        #12;
        // 1. reset state
        check_eq("rst.po", 32'(PO), 32'hA5);
        check_eq("rst.sol", 32'(SO_L), 32'd1);
        check_eq("rst.sor", 32'(SO_R), 32'd1);
        check_eq("rst.busy", 32'(BUSY), 32'd0);
        check_eq("rst.done", 32'(DONE), 32'd0);
        RESET = 1'b0;
        step("idle0");

        // asynchronous reset mid-burst (LEN=6, after third shift)
        START = 1; LEN = 6; DIR = 0; SI = 0; step("ab.acc");
        START = 0;
        for (int i = 0; i < 3; i++) step("ab.sh");
        #2 RESET = 1'b1;
        #1;
        check_eq("arst.po", 32'(PO), 32'hA5);
        check_eq("arst.busy", 32'(BUSY), 32'd0);
        model_reset();
        step("arst.hold");
        #3 RESET = 1'b0;

        // 2. SISO left and right
        stream = 8'b1011_0010;
        MODE = 3'd6; step("clr");
        for (int d = 0; d < 2; d++) begin
            MODE = (d == 0) ? 3'd1 : 3'd2;
            for (int i = 0; i < 16; i++) begin
                SI = (i < 8) ? stream[7 - i] : 1'b0;
                step("siso");
                if (i >= 7 && i < 15)
                    check_eq(d == 0 ? "siso.l" : "siso.r", 32'(d == 0 ? SO_L : SO_R),
                             32'(stream[7 - (i - 7)]));
            end
        end

        // 3. load / rotate / clear / reserved
        MODE = 3'd5; PI = 8'h81; step("ld");  check_eq("ld81", 32'(PO), 32'h81);
        MODE = 3'd3; step("rol");             check_eq("rol", 32'(PO), 32'h03);
        MODE = 3'd5; step("ld2");
        MODE = 3'd4; step("ror");             check_eq("ror", 32'(PO), 32'hC0);
        MODE = 3'd6; step("clr2");            check_eq("clr", 32'(PO), 32'h00);
        MODE = 3'd5; PI = 8'h5A; step("ld3");
        MODE = 3'd7; step("rsv");             check_eq("rsv", 32'(PO), 32'h5A);

        // 4. burst left with MODE=1 ignored, then burst right
        MODE = 3'd5; PI = 8'h3C; step("ld3c");
        MODE = 3'd1; START = 1; LEN = 4; DIR = 0; SI = 0; step("bl.acc");
        check_eq("bl.acc.po", 32'(PO), 32'h3C);
        START = 0;
        step("bl1"); check_eq("bl.78", 32'(PO), 32'h78);
        step("bl2"); check_eq("bl.f0", 32'(PO), 32'hF0);
        step("bl3"); check_eq("bl.e0", 32'(PO), 32'hE0);
        step("bl4"); check_eq("bl.c0", 32'(PO), 32'hC0);
        check_eq("bl.done", 32'(DONE), 32'd1);
        MODE = 3'd5; PI = 8'h3C; step("ld3c2");
        MODE = 3'd0; START = 1; LEN = 4; DIR = 1; SI = 1; step("br.acc");
        START = 0;
        for (int i = 0; i < 4; i++) step("br");
        check_eq("br.f3", 32'(PO), 32'hF3);
        step("br.after"); check_eq("br.doneclr", 32'(DONE), 32'd0);

        // 5. LEN=0, ignored START while busy, START in DONE cycle
        START = 1; LEN = 0; step("l0"); check_eq("l0.done", 32'(DONE), 32'd1);
        START = 0; step("l0b");
        START = 1; LEN = 5; DIR = 0; SI = 1; step("b5.acc");
        LEN = 2; busy_cycles = 0;
        for (int i = 0; i < 8 && BUSY; i++) begin
            step("b5"); busy_cycles++;
        end
        check_eq("b5.shifts", 32'(busy_cycles), 32'd5);
        LEN = 3; step("b2b.acc");
        check_eq("b2b.busy", 32'(BUSY), 32'd1);
        START = 0;
        for (int i = 0; i < 3; i++) step("b2b");

        // 6. CE gating mid-burst and on DONE
        START = 1; LEN = 5; DIR = 1; SI = 0; step("ce.acc");
        START = 0; step("ce.s1"); step("ce.s2");
        CE = 0;
        for (int i = 0; i < 3; i++) step("ce.frz");
        CE = 1;
        for (int i = 0; i < 3; i++) step("ce.s");
        check_eq("ce.done", 32'(DONE), 32'd1);
        CE = 0; step("ce.dh1"); step("ce.dh2");
        check_eq("ce.donehold", 32'(DONE), 32'd1);
        CE = 1; step("ce.dclr");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            CE    = ($urandom_range(0, 7) != 0);
            MODE  = 3'($urandom_range(0, 7));
            SI    = 1'($urandom);
            PI    = 8'($urandom);
            START = ($urandom_range(0, 5) == 0);
            LEN   = 4'($urandom_range(0, 15));
            DIR   = 1'($urandom);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uni_shift_reg.md
# uni_shift_reg

Parametrised universal shift register: the successor to the fixed three-stage serial-in/serial-out shifter. Adds configurable width, reset value, clock enable, bidirectional shift, rotate, parallel load/clear and a burst engine that performs a programmed number of shifts autonomously with a BUSY/DONE handshake. It sits between board I/O (switches, serial lines) and parallel logic, serving as SISO, SIPO, PISO or barrel-style rotator.

## Interface
- N, default 8: register width, N >= 2.
- INIT, default 0: N-bit reset value of the register.
- CW, derived, ceil(log2(N+1)): width of LEN and the internal shift counter.
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- CE  in  1  clock enable; when 0 every state element (register, counter, FSM, DONE) holds.
- MODE  in  3  manual operation select; ignored while BUSY=1 or when START is accepted.
- SI  in  1  serial input for shifts; ignored for rotates.
- PI  in  N  parallel load data.
- START  in  1  burst request.
- LEN  in  CW  burst shift count, sampled when START is accepted.
- DIR  in  1  burst direction, sampled with START: 0 = left, 1 = right.
- PO  out  N  register contents Q.
- SO_L  out  1  Q[N-1], the left-shift serial output.
- SO_R  out  1  Q[0], the right-shift serial output.
- BUSY  out  1  burst in progress.
- DONE  out  1  burst-complete pulse.

## Operation
- Left shift: Q <= {Q[N-2:0], SI}. With SI as input and SO_L as output, this gives SISO with N-cycle latency.
- Right shift: Q <= {SI, Q[N-1:1]}.
- MODE encoding, applied when CE=1, idle, and no START:
  - 0: hold
  - 1: shift left
  - 2: shift right
  - 3: rotate left, {Q[N-2:0], Q[N-1]}
  - 4: rotate right, {Q[0], Q[N-1:1]}
  - 5: load PI
  - 6: clear to 0
  - 7: hold (reserved)
- FSM states: IDLE, SHIFT.
- IDLE, CE=1, START=1, LEN>0:
  - CNT <= LEN; DIR latched; -> SHIFT; BUSY <= 1.
  - No shift on the accept edge. MODE is ignored that cycle.
- IDLE, CE=1, START=1, LEN=0: stay IDLE; DONE <= 1; Q unchanged.
- SHIFT, CE=1:
  - One shift per edge in the latched direction, SI entering.
  - CNT decrements.
  - On the edge where CNT goes 1->0: -> IDLE, BUSY <= 0, DONE <= 1.
- START while BUSY=1 is ignored; no queueing. MODE is ignored while BUSY=1.
- DONE:
  - Set only on burst completion.
  - Cleared on the next CE=1 edge, unless that edge completes another (LEN=0) burst.
  - With CE=0, DONE stays high.
- LEN values greater than N are legal: the register shifts that many times, so it is fully filled from SI.

## Timing
- Reset (asynchronous, immediate, including mid-burst): Q=INIT, PO=INIT, SO_L=INIT[N-1], SO_R=INIT[0], BUSY=0, DONE=0, CNT=0, FSM=IDLE.
- The first edge after RESET deasserts behaves as IDLE.
- All outputs are registered or direct bits of Q; no combinational input-to-output paths.
- Manual modes: result is visible on PO one cycle after the edge.
- Burst accepted at edge k with LEN=L>0:
  - BUSY high from after edge k until edge k+L.
  - Shifts occur at edges k+1 through k+L.
  - DONE is high for the cycle after edge k+L, when final PO is valid.
- Burst with LEN=0: DONE is high for the cycle after edge k; BUSY is never asserted.
- CE=0 edges are skipped entirely. Latency counts CE=1 edges only.
- Back-to-back bursts: a START in the cycle where DONE=1 is accepted, since the FSM is IDLE. DONE then clears on that edge.

## Test plan
1. Reset with N=8, INIT=8'hA5 -> PO=A5, SO_L=1, SO_R=1, BUSY=0, DONE=0. Assert RESET at the third shift of a LEN=6 burst -> PO=A5 and BUSY=0 immediately, without waiting for a clock edge.
2. SISO: MODE=1, CE=1, SI stream 1,0,1,1,0,0,1,0 then zeros -> SO_L reproduces the stream delayed by exactly 8 cycles. MODE=2 with the same stream -> SO_R reproduces it with an 8-cycle delay.
3. Load and rotate: MODE=5 with PI=8'h81 -> PO=81. MODE=3 -> 03. Reload 81, MODE=4 -> C0. MODE=6 -> 00. MODE=7 -> hold.
4. Burst: load 8'h3C; START, LEN=4, DIR=0, SI=0, while MODE=1 -> MODE ignored. BUSY high 4 cycles; PO sequence 78, F0, E0, C0. DONE high one cycle with PO=C0. DIR=1 from 8'h3C with SI=1 -> PO=F3.
5. Edge cases:
   - LEN=0 -> DONE pulse next cycle, PO unchanged, BUSY never 1.
   - START with LEN=2 during a LEN=5 burst -> ignored; burst still takes 5 shifts.
   - START in the DONE cycle -> new burst accepted.
6. CE gating: drop CE for 3 cycles mid-burst (LEN=5) -> PO, BUSY and counter frozen; burst completes after 5 CE=1 shift edges. CE=0 while DONE=1 -> DONE stays high until the next CE=1 edge.
